// File: rtl/sram_1rw1r_sync_model.sv
// ----------------------------------------------------------------------------
// sram_1rw1r_sync_model
//
// Parametrised single-clock SRAM model with one read/write port (port 0) and
// one read-only port (port 1). Both read ports have registered outputs with a
// one-edge latency and a matching data-valid flag. A port 0 write and a port 1
// read of the same in-range address on the same edge is flagged as a
// collision. Port 1 then returns either the newly merged word (BYPASS=1) or the
// pre-write word (BYPASS=0). With INIT_CLEAR=1 a clear engine zeroes every
// word after reset and holds off all requests while it runs.
//
// Ports:
//   clk0       single clock, all logic on its rising edge
//   rstb0      asynchronous active-low reset
//   csb0       port 0 chip select, active low
//   web0       port 0 write enable, active low (1 = read)
//   wmask0     port 0 per-lane write enable, active high
//   addr0      port 0 address
//   din0       port 0 write data
//   dout0      port 0 registered read data
//   dvalid0    dout0 was loaded by a read on the last edge
//   csb1       port 1 chip select, active low
//   addr1      port 1 address
//   dout1      port 1 registered read data
//   dvalid1    dout1 was loaded by a read on the last edge
//   busy       clear engine running, every request is ignored
//   collision  one-cycle pulse: same-address port 0 write / port 1 read
//   drop       one-cycle pulse: a request was ignored (busy or out of range)
// ----------------------------------------------------------------------------
module sram_1rw1r_sync_model #(
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 8,
    parameter int NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH,
    parameter int ADDR_WIDTH  = 11,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter bit BYPASS      = 1'b1,
    parameter bit INIT_CLEAR  = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1,
    output logic                  busy,
    output logic                  collision,
    output logic                  drop
);

    // Parameter sanity checks, reported at elaboration.
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask_width
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (NUM_WMASKS != DATA_WIDTH / WMASK_WIDTH) begin : g_bad_num_wmasks
        $error("NUM_WMASKS is derived and must not be overridden");
    end
    if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("RAM_DEPTH must not exceed 2**ADDR_WIDTH");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    // One extra bit so the compare also works when RAM_DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  ready;
    logic                  addr0_ok, addr1_ok;
    logic [ADDR_WIDTH-1:0] addr0_idx, addr1_idx;
    logic                  wr0, rd0, rd1, hit, drop_d;
    logic [DATA_WIDTH-1:0] merged1;

    assign ready    = (state_q == ST_READY);
    assign busy     = (state_q == ST_CLEAR);
    assign addr0_ok = ({1'b0, addr0} < DEPTH_EXT);
    assign addr1_ok = ({1'b0, addr1} < DEPTH_EXT);

    // Out-of-range addresses are steered to word 0 so that no array access
    // ever indexes past the end; the request itself is suppressed anyway.
    assign addr0_idx = addr0_ok ? addr0 : '0;
    assign addr1_idx = addr1_ok ? addr1 : '0;

    assign wr0 = ready && !csb0 && !web0 && addr0_ok;
    assign rd0 = ready && !csb0 &&  web0 && addr0_ok;
    assign rd1 = ready && !csb1 && addr1_ok;
    assign hit = wr0 && rd1 && (addr0 == addr1);

    // Any selected port is dropped while clearing; once ready only an
    // out-of-range address causes a drop.
    assign drop_d = (!ready && (!csb0 || !csb1))
                 || (ready && !csb0 && !addr0_ok)
                 || (ready && !csb1 && !addr1_ok);

    // Word port 1 would see after this edge's port 0 write lands: written
    // lanes come from din0, the rest from the stored word.
    always_comb begin
        merged1 = mem[addr1_idx];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
                merged1[i*WMASK_WIDTH +: WMASK_WIDTH] = din0[i*WMASK_WIDTH +: WMASK_WIDTH];
            end
        end
    end

    // Clear engine state register; a reset mid-clear restarts from word 0.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q <= INIT_CLEAR ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Walk the counter across every word, leaving CLEAR after the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_READY;
            end
        end
    end

    // Storage array. It has no reset of its own; gating on rstb0 keeps the
    // array untouched while reset is held.
    always_ff @(posedge clk0) begin
        if (rstb0) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt_q] <= '0;
            end else if (wr0) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (wmask0[i]) begin
                        mem[addr0_idx][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
                    end
                end
            end
        end
    end

    // Registered read data and status pulses. Data registers only load on
    // a valid read, so they hold across idle, write and dropped cycles.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            dout0     <= '0;
            dout1     <= '0;
            dvalid0   <= 1'b0;
            dvalid1   <= 1'b0;
            collision <= 1'b0;
            drop      <= 1'b0;
        end else begin
            dvalid0   <= rd0;
            dvalid1   <= rd1;
            collision <= hit;
            drop      <= drop_d;
            if (rd0) begin
                dout0 <= mem[addr0_idx];
            end
            if (rd1) begin
                dout1 <= (BYPASS && hit) ? merged1 : mem[addr1_idx];
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw1r_sync_model.sv
// ----------------------------------------------------------------------------
// tb_sram_1rw1r_sync_model
//
// Self-checking bench for sram_1rw1r_sync_model, built with a 12-word, 4-bit
// address configuration so both the clear engine and out-of-range addresses
// are reachable. A word-level reference model (an array plus the expected
// output registers) is advanced once per clock edge from the current inputs.
// ----------------------------------------------------------------------------
module tb_sram_1rw1r_sync_model;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 12;
    localparam int NMASK = 4;
    localparam bit BYP   = 1'b1;

    logic             clk0;
    logic             rstb0;
    logic             csb0;
    logic             web0;
    logic [NMASK-1:0] wmask0;
    logic [AW-1:0]    addr0;
    logic [DW-1:0]    din0;
    logic [DW-1:0]    dout0;
    logic             dvalid0;
    logic             csb1;
    logic [AW-1:0]    addr1;
    logic [DW-1:0]    dout1;
    logic             dvalid1;
    logic             busy;
    logic             collision;
    logic             drop;

    sram_1rw1r_sync_model #(
        .DATA_WIDTH (DW),
        .WMASK_WIDTH(8),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH),
        .BYPASS     (BYP),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk0     (clk0),
        .rstb0    (rstb0),
        .csb0     (csb0),
        .web0     (web0),
        .wmask0   (wmask0),
        .addr0    (addr0),
        .din0     (din0),
        .dout0    (dout0),
        .dvalid0  (dvalid0),
        .csb1     (csb1),
        .addr1    (addr1),
        .dout1    (dout1),
        .dvalid1  (dvalid1),
        .busy     (busy),
        .collision(collision),
        .drop     (drop)
    );

    always #5 clk0 = ~clk0;

    // Reference model state.
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_dout0, exp_dout1;
    logic          exp_dv0, exp_dv1, exp_col, exp_drop;
    int            busy_left;

    int n_checks = 0;
    int n_fail   = 0;

    // After any reset the clear engine leaves every word at zero before a
    // request can be accepted, so the model zeroes its array immediately.
    task automatic model_reset();
        exp_dout0 = '0;
        exp_dout1 = '0;
        exp_dv0   = 1'b0;
        exp_dv1   = 1'b0;
        exp_col   = 1'b0;
        exp_drop  = 1'b0;
        busy_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
    endtask

    // Advance the model by one clock edge using the inputs as driven now.
    task automatic model_edge();
        bit            in0, in1;
        logic [DW-1:0] m, word;
        in0 = int'(addr0) < DEPTH;
        in1 = int'(addr1) < DEPTH;
        exp_dv0  = 1'b0;
        exp_dv1  = 1'b0;
        exp_col  = 1'b0;
        if (busy_left > 0) begin
            exp_drop = !csb0 || !csb1;
            busy_left--;
            return;
        end
        exp_drop = (!csb0 && !in0) || (!csb1 && !in1);
        if (!csb0 && web0 && in0) begin
            exp_dout0 = exp_mem[addr0];
            exp_dv0   = 1'b1;
        end
        if (!csb1 && in1) begin
            exp_dout1 = exp_mem[addr1];
            exp_dv1   = 1'b1;
        end
        if (!csb0 && !web0 && in0) begin
            for (int b = 0; b < DW; b++) m[b] = wmask0[b / 8];
            word = (exp_mem[addr0] & ~m) | (din0 & m);
            exp_mem[addr0] = word;
            if (!csb1 && in1 && addr1 == addr0) begin
                exp_col = 1'b1;
                if (BYP) exp_dout1 = word;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle_inputs();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        csb1   = 1'b1;
    endtask

    task automatic test_reset();
        int busy_cycles;
        rstb0 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk0);
        #1;
        n_checks++; if (dout0 !== '0) begin n_fail++; $display("[TB] FAIL reset_dout0: got %h want 0", dout0); end
        n_checks++; if (dout1 !== '0) begin n_fail++; $display("[TB] FAIL reset_dout1: got %h want 0", dout1); end
        n_checks++; if ({dvalid0, dvalid1, collision, drop} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {dvalid0, dvalid1, collision, drop}); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
        rstb0 = 1'b1;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        // Requests issued while clearing must be dropped and leave no trace.
        for (int i = 0; i < DEPTH + 2; i++) begin
            csb0   = !((i < DEPTH) && (i % 2 == 0));
            web0   = 1'b0;
            wmask0 = 4'hF;
            addr0  = 4'd3;
            din0   = $urandom;
            csb1   = !((i < DEPTH) && (i % 3 == 0));
            addr1  = 4'd3;
            step();
            if (busy === 1'b1) busy_cycles++;
            n_checks++; if (busy !== (busy_left > 0)) begin n_fail++; $display("[TB] FAIL clear_busy cyc %0d: got %b want %b", i, busy, busy_left > 0); end
            n_checks++; if (drop !== exp_drop) begin n_fail++; $display("[TB] FAIL clear_drop cyc %0d: got %b want %b", i, drop, exp_drop); end
            n_checks++; if ({dvalid0, dvalid1} !== 2'b00) begin n_fail++; $display("[TB] FAIL clear_dvalid cyc %0d: got %b want 00", i, {dvalid0, dvalid1}); end
        end
        idle_inputs();
        n_checks++; if (busy_cycles != DEPTH) begin n_fail++; $display("[TB] FAIL busy_length: got %0d want %0d", busy_cycles, DEPTH); end
    endtask

    task automatic test_clear_reads();
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            csb1  = 1'b0;
            addr1 = AW'(a);
            step();
            n_checks++; if (dvalid1 !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_rd_dvalid1 addr %0d: got %b want 1", a, dvalid1); end
            n_checks++; if (dout1 !== '0) begin n_fail++; $display("[TB] FAIL clear_rd_dout1 addr %0d: got %h want 0", a, dout1); end
        end
        idle_inputs();
        step();
        n_checks++; if (dvalid1 !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_rd_idle_dvalid1: got %b want 0", dvalid1); end
    endtask

    task automatic test_mask_write();
        idle_inputs();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 4'd5; din0 = 32'h11223344;
        step();
        // Mask 0101 takes lanes 0 and 2 from din0 and keeps lanes 1 and 3.
        wmask0 = 4'b0101; din0 = 32'hAABBCCDD;
        step();
        n_checks++; if (dvalid0 !== 1'b0) begin n_fail++; $display("[TB] FAIL mask_wr_dvalid0: got %b want 0", dvalid0); end
        wmask0 = 4'b0000; din0 = 32'hFFFFFFFF;
        step();
        web0 = 1'b1;
        step();
        n_checks++; if (dout0 !== 32'h11BB33DD) begin n_fail++; $display("[TB] FAIL mask_rd_dout0: got %h want 11bb33dd", dout0); end
        n_checks++; if (dvalid0 !== 1'b1) begin n_fail++; $display("[TB] FAIL mask_rd_dvalid0: got %b want 1", dvalid0); end
        idle_inputs();
        step();
        n_checks++; if (dout0 !== 32'h11BB33DD) begin n_fail++; $display("[TB] FAIL mask_hold_dout0: got %h want 11bb33dd", dout0); end
    endtask

    task automatic test_collision();
        logic [DW-1:0] want;
        idle_inputs();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 4'd7; din0 = 32'hDEADBEEF;
        csb1 = 1'b0; addr1 = 4'd7;
        step();
        want = BYP ? 32'hDEADBEEF : 32'h0;
        n_checks++; if (collision !== 1'b1) begin n_fail++; $display("[TB] FAIL col_pulse: got %b want 1", collision); end
        n_checks++; if (dout1 !== want) begin n_fail++; $display("[TB] FAIL col_dout1: got %h want %h", dout1, want); end
        idle_inputs();
        step();
        n_checks++; if (collision !== 1'b0) begin n_fail++; $display("[TB] FAIL col_single: got %b want 0", collision); end
        csb1 = 1'b0; addr1 = 4'd7;
        step();
        n_checks++; if (dout1 !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL col_after_rd: got %h want deadbeef", dout1); end
        // Partial-mask collision: low two lanes new, high two lanes old.
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0011; addr0 = 4'd7; din0 = 32'h01020304;
        step();
        want = BYP ? 32'hDEAD0304 : 32'hDEADBEEF;
        n_checks++; if (dout1 !== want) begin n_fail++; $display("[TB] FAIL col_merge_dout1: got %h want %h", dout1, want); end
        n_checks++; if (collision !== 1'b1) begin n_fail++; $display("[TB] FAIL col_merge_pulse: got %b want 1", collision); end
        // Both ports reading the same word is not a collision.
        web0 = 1'b1;
        step();
        n_checks++; if (collision !== 1'b0) begin n_fail++; $display("[TB] FAIL dual_rd_col: got %b want 0", collision); end
        n_checks++; if (dout0 !== 32'hDEAD0304) begin n_fail++; $display("[TB] FAIL dual_rd_dout0: got %h want dead0304", dout0); end
        n_checks++; if (dout1 !== 32'hDEAD0304) begin n_fail++; $display("[TB] FAIL dual_rd_dout1: got %h want dead0304", dout1); end
        idle_inputs();
        step();
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] held0;
        idle_inputs();
        csb1 = 1'b0; addr1 = 4'd13;
        step();
        n_checks++; if (drop !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_rd1_drop: got %b want 1", drop); end
        n_checks++; if (dvalid1 !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_rd1_dvalid1: got %b want 0", dvalid1); end
        n_checks++; if (dout1 !== exp_dout1) begin n_fail++; $display("[TB] FAIL oor_rd1_hold: got %h want %h", dout1, exp_dout1); end
        idle_inputs();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 4'd12; din0 = 32'h5A5A5A5A;
        step();
        n_checks++; if (drop !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_wr_drop: got %b want 1", drop); end
        held0 = exp_dout0;
        web0 = 1'b1;
        step();
        n_checks++; if (dvalid0 !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_rd0_dvalid0: got %b want 0", dvalid0); end
        n_checks++; if (dout0 !== held0) begin n_fail++; $display("[TB] FAIL oor_rd0_hold: got %h want %h", dout0, held0); end
        // Highest legal address behaves normally.
        web0 = 1'b0; addr0 = 4'd11; din0 = 32'hCAFEF00D;
        step();
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("[TB] FAIL edge_wr_drop: got %b want 0", drop); end
        idle_inputs();
        csb1 = 1'b0; addr1 = 4'd11;
        step();
        n_checks++; if (dout1 !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL edge_rd_dout1: got %h want cafef00d", dout1); end
        idle_inputs();
        step();
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_not_sticky: got %b want 0", drop); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            vals[k] = $urandom;
            csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = AW'(k + 1); din0 = vals[k];
            step();
        end
        for (int k = 0; k < 3; k++) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(k + 1);
            step();
            n_checks++; if (dout0 !== vals[k]) begin n_fail++; $display("[TB] FAIL b2b_dout0 addr %0d: got %h want %h", k + 1, dout0, vals[k]); end
            n_checks++; if (dvalid0 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_dvalid0 addr %0d: got %b want 1", k + 1, dvalid0); end
        end
        idle_inputs();
        step();
        n_checks++; if (dout0 !== vals[2]) begin n_fail++; $display("[TB] FAIL b2b_hold_dout0: got %h want %h", dout0, vals[2]); end
        n_checks++; if (dvalid0 !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_hold_dvalid0: got %b want 0", dvalid0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            csb0   = ($urandom_range(0, 3) == 0);
            web0   = 1'($urandom_range(0, 1));
            wmask0 = 4'($urandom_range(0, 15));
            addr0  = 4'($urandom_range(0, 15));
            din0   = $urandom;
            csb1   = ($urandom_range(0, 3) == 0);
            addr1  = ($urandom_range(0, 2) == 0) ? addr0 : 4'($urandom_range(0, 15));
            step();
            n_checks++; if (dout0 !== exp_dout0) begin n_fail++; $display("[TB] FAIL rand_dout0 cyc %0d: got %h want %h", i, dout0, exp_dout0); end
            n_checks++; if (dout1 !== exp_dout1) begin n_fail++; $display("[TB] FAIL rand_dout1 cyc %0d: got %h want %h", i, dout1, exp_dout1); end
            n_checks++; if (dvalid0 !== exp_dv0) begin n_fail++; $display("[TB] FAIL rand_dvalid0 cyc %0d: got %b want %b", i, dvalid0, exp_dv0); end
            n_checks++; if (dvalid1 !== exp_dv1) begin n_fail++; $display("[TB] FAIL rand_dvalid1 cyc %0d: got %b want %b", i, dvalid1, exp_dv1); end
            n_checks++; if (collision !== exp_col) begin n_fail++; $display("[TB] FAIL rand_collision cyc %0d: got %b want %b", i, collision, exp_col); end
            n_checks++; if (drop !== exp_drop) begin n_fail++; $display("[TB] FAIL rand_drop cyc %0d: got %b want %b", i, drop, exp_drop); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_busy cyc %0d: got %b want 0", i, busy); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_clear();
        int busy_cycles;
        idle_inputs();
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 4'd5; din0 = 32'h12345678;
        step();
        web0 = 1'b1; csb1 = 1'b0; addr1 = 4'd5;
        step();
        n_checks++; if (dout0 !== 32'h12345678) begin n_fail++; $display("[TB] FAIL pre_rst_dout0: got %h want 12345678", dout0); end
        n_checks++; if (dout1 !== 32'h12345678) begin n_fail++; $display("[TB] FAIL pre_rst_dout1: got %h want 12345678", dout1); end
        idle_inputs();
        #2;
        rstb0 = 1'b0;
        model_reset();
        #1;
        n_checks++; if (dout0 !== '0) begin n_fail++; $display("[TB] FAIL async_rst_dout0: got %h want 0", dout0); end
        n_checks++; if (dout1 !== '0) begin n_fail++; $display("[TB] FAIL async_rst_dout1: got %h want 0", dout1); end
        n_checks++; if ({dvalid0, dvalid1} !== 2'b00) begin n_fail++; $display("[TB] FAIL async_rst_dvalid: got %b want 00", {dvalid0, dvalid1}); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL async_rst_busy: got %b want 1", busy); end
        @(posedge clk0);
        #1;
        rstb0 = 1'b1;
        csb1 = 1'b0; addr1 = 4'd0;
        repeat (9) step();
        n_checks++; if (drop !== exp_drop) begin n_fail++; $display("[TB] FAIL mid_clear_drop: got %b want %b", drop, exp_drop); end
        rstb0 = 1'b0;
        model_reset();
        #1;
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_drop: got %b want 0", drop); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_busy: got %b want 1", busy); end
        @(posedge clk0);
        #1;
        rstb0 = 1'b1;
        idle_inputs();
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            step();
            if (busy === 1'b1) busy_cycles++;
        end
        n_checks++; if (busy_cycles != DEPTH) begin n_fail++; $display("[TB] FAIL restart_busy_length: got %0d want %0d", busy_cycles, DEPTH); end
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
        step();
        n_checks++; if (dout0 !== '0) begin n_fail++; $display("[TB] FAIL recleared_dout0: got %h want 0", dout0); end
        n_checks++; if (dvalid0 !== 1'b1) begin n_fail++; $display("[TB] FAIL recleared_dvalid0: got %b want 1", dvalid0); end
        idle_inputs();
    endtask

    initial begin
        clk0   = 1'b0;
        rstb0  = 1'b0;
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        csb1   = 1'b1;
        addr1  = '0;
        test_reset();
        test_clear_reads();
        test_mask_write();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
